hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit that executes the ALU's `mult`, `multu`, `div` and `divu` operations over multiple cycles and holds the architectural HI/LO results. It sits directly downstream of the combinational ALU. The ALU decode issues a start with the operand pair. This block computes the result, then presents HI/LO to the writeback/`mfhi`/`mflo` path. A start/busy/done handshake lets the pipeline stall while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only while idle.
- `op`  in  2  operation: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `a`  in  WIDTH  operand A (multiplicand or dividend).
- `b`  in  WIDTH  operand B (multiplier or divisor).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `hi`  out  WIDTH  multiply: upper product half; divide: remainder.
- `lo`  out  WIDTH  multiply: lower product half; divide: quotient.
- `div_by_zero`  out  1  flag; set when the last completed divide had `b`==0.

## Operation
- Reset (async, `rst_n`=0): state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi` = `lo` = 0; the iteration counter is cleared. Reset mid-operation aborts the operation and the result is discarded.
- FSM states are IDLE, CALC, FIX.
- IDLE:
  - `start`=1 latches `op`, `a`, `b`, clears `div_by_zero`, and moves to CALC.
  - For signed ops, the operand magnitudes and the result sign are latched.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC, multiply: radix-2 shift-add on magnitudes, one bit per cycle, WIDTH iterations, into a 2×WIDTH accumulator.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations.
- After the last iteration the FSM moves to FIX.
- FIX:
  - Apply two's-complement negation where the latched signs require it.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Divide by zero (`op`=1x, `b`=0 at start):
  - Skip CALC and go from IDLE straight to FIX.
  - Result: `hi`=a, `lo`=all ones, `div_by_zero`=1.
- Width rules:
  - A magnitude of −2^(WIDTH−1) is held as an unsigned WIDTH-bit value. No overflow trap.
  - `div` of 0x80000000 by 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- `start` while busy is ignored: no latch and no effect on the result.
- `hi`/`lo`/`div_by_zero` hold their values until the next FIX.

## Timing
- Start edge E0 = the rising edge where IDLE samples `start`=1.
- Normal op:
  - CALC occupies edges E1..E32 (WIDTH edges).
  - FIX executes at E33. `hi`/`lo` are valid and `done`=1 for the cycle after E33.
  - Latency is WIDTH+1 cycles from E0.
- Divide by zero: FIX executes at E1, and `done` is high for the cycle after E1.
- `busy` = (state ≠ IDLE).
  - It is high from after E0 through E33.
  - It is low in the `done` cycle.
- `done` is registered, high exactly one cycle, and never asserted while `busy`=1.
- A `start` in the `done` cycle is accepted; that edge becomes the next E0. Back-to-back ops therefore have a throughput of one per WIDTH+2 cycles.
- Operands may change freely after E0.

## Test plan
- `mult`, a=0x80000002, b=0x00000002 -> after 33 cycles `hi`=0xFFFFFFFF, `lo`=0x00000004, `done` one-cycle pulse.
- `multu`, same operands -> `hi`=0x00000001, `lo`=0x00000004; `busy` high for exactly 33 cycles.
- `div` 9/2 -> `lo`=4, `hi`=1. `div` a=0xFFFFFFF9 (−7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. `div` 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- `divu` a=b=0x80000001 -> `lo`=1, `hi`=0. `divu` a=5, b=0 -> `done` the cycle after E1, `hi`=5, `lo`=0xFFFFFFFF, `div_by_zero`=1.
- Handshake sequence:
  - Start `multu` 3×4.
  - Pulse `start` with `div` 100/7 at cycle 10 -> ignored; the result is still `hi`=0, `lo`=12.
  - Start in the `done` cycle -> accepted; 100/7 gives `lo`=14, `hi`=2.
  - `div_by_zero` clears at that start.
- Drop `rst_n` at cycle 15 of a `mult` -> all outputs 0 immediately (async), state IDLE.
  - No `done` pulse follows.
  - A new op after reset release completes normally.

Source files
------------

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO results.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module hilo_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dbz_pend_q, dbz_pend_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   // Operand signs only count for the signed ops (op[0] == 0).
   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign sgn_a = ~op[0] & a[WIDTH-1];
   assign sgn_b = ~op[0] & b[WIDTH-1];
   assign mag_a = sgn_a ? -a : a;
   assign mag_b = sgn_b ? -b : b;

   // Multiply: acc = {partial product, remaining multiplier bits}; the carry
   // out of the add becomes the new top bit as the whole thing shifts right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}.
   logic [WIDTH:0]     div_rem, div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_step;

   assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = div_rem - {1'b0, opd_q};
   assign div_ok   = ~div_diff[WIDTH];
   assign div_step = {(div_ok ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ok};

   logic [WIDTH-1:0]   q_mag, r_mag;
   logic [2*WIDTH-1:0] prod_fix;

   assign q_mag    = acc_q[WIDTH-1:0];
   assign r_mag    = acc_q[2*WIDTH-1:WIDTH];
   assign prod_fix = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opd_d      = opd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      dbz_pend_d = dbz_pend_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               is_div_d = op[1];
               opd_d    = op[1] ? mag_b : mag_a;
               acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
               neg_d    = sgn_a ^ sgn_b;
               rneg_d   = sgn_a;
               dbz_d    = 1'b0;
               cnt_d    = '0;
               if (op[1] && (b == '0)) begin
                  // Raw dividend is parked in acc so FIX can return it as HI.
                  dbz_pend_d = 1'b1;
                  acc_d      = {{WIDTH{1'b0}}, a};
                  state_d    = StFix;
               end else begin
                  dbz_pend_d = 1'b0;
                  state_d    = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d = is_div_q ? div_step : mul_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (dbz_pend_q) begin
               hi_d  = acc_q[WIDTH-1:0];
               lo_d  = '1;
               dbz_d = 1'b1;
            end else if (is_div_q) begin
               hi_d = rneg_q ? -r_mag : r_mag;
               lo_d = neg_q ? -q_mag : q_mag;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opd_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         dbz_pend_q <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opd_q      <= opd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         dbz_pend_q <= dbz_pend_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv: results, latency, handshake and
// asynchronous reset abort.
module tb_hilo_muldiv;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hilo_muldiv #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for one edge (E0); operands are scrambled afterwards.
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      step();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Returns in the done cycle; lat = edges from now until done is seen.
   task automatic wait_done(input string tag, input int lat);
      int n      = 0;
      int busy_n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_n++;
         step();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
      check({tag, "_busy_in_done"}, 64'(busy), 64'(0));
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] ehi,
                      input logic [WIDTH-1:0] elo, input logic edbz, input int lat);
      issue(o, x, y);
      check({tag, "_dbz_cleared"}, 64'(div_by_zero), 64'(0));
      wait_done(tag, lat);
      check({tag, "_hi"}, 64'(hi), 64'(ehi));
      check({tag, "_lo"}, 64'(lo), 64'(elo));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
      step();
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_hold_lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      int done_seen;

      repeat (3) step();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_dbz", 64'(div_by_zero), 64'(0));
      rst_n = 1'b1;
      step();

      run("mult", 2'b00, 32'h8000_0002, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0, 33);
      run("multu", 2'b01, 32'h8000_0002, 32'h0000_0002, 32'h0000_0001, 32'h0000_0004, 1'b0, 33);
      run("div_9_2", 2'b10, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 33);
      run("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      run("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
      run("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
      run("divu_eq", 2'b11, 32'h8000_0001, 32'h8000_0001, 32'd0, 32'd1, 1'b0, 33);
      run("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);

      // Handshake: start while busy is ignored, start in the done cycle is taken.
      issue(2'b01, 32'd3, 32'd4);
      check("hs_dbz_cleared", 64'(div_by_zero), 64'(0));
      repeat (10) step();
      op    = 2'b10;
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("hs_mult", 22);
      check("hs_mult_hi", 64'(hi), 64'(0));
      check("hs_mult_lo", 64'(lo), 64'(12));
      issue(2'b10, 32'd100, 32'd7);
      check("hs_div_accepted_busy", 64'(busy), 64'(1));
      check("hs_div_done_low", 64'(done), 64'(0));
      wait_done("hs_div", 33);
      check("hs_div_hi", 64'(hi), 64'(2));
      check("hs_div_lo", 64'(lo), 64'(14));
      step();

      // Asynchronous reset mid-multiply.
      issue(2'b00, 32'd7, 32'd3);
      repeat (14) step();
      check("abort_busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_hi", 64'(hi), 64'(0));
      check("abort_lo", 64'(lo), 64'(0));
      check("abort_dbz", 64'(div_by_zero), 64'(0));
      repeat (2) step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'(0));
      run("post_rst_mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
